// File: rtl/fp_elastic_delay_pkg.sv
// fp_delay_pkg: shared widths, width helper and default word layout for the elastic delay line
package fp_delay_pkg;
  localparam int MANTISSA_LENGTH_DEF = 23;
  localparam int EXP_LENGTH_DEF = 8;
  function automatic int fp_width(input int mant, input int exp);
    return mant + exp + 1;
  endfunction
  typedef struct packed {
    logic sign;
    logic [EXP_LENGTH_DEF-1:0] exp;
    logic [MANTISSA_LENGTH_DEF-1:0] mant;
  } fp_word_t;
endpackage

// File: rtl/fp_elastic_delay_if.sv
// fp_elastic_delay_if: upstream/downstream valid-ready handshake and occupancy of the delay line
interface fp_elastic_delay_if
  import fp_delay_pkg::*;
#(
  parameter int MANTISSA_LENGTH = MANTISSA_LENGTH_DEF,
  parameter int EXP_LENGTH = EXP_LENGTH_DEF,
  parameter int DEPTH = 4
);
  localparam int W = fp_width(MANTISSA_LENGTH, EXP_LENGTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [CW-1:0] occupancy;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/fp_elastic_delay_stage.sv
// fp_delay_stage: one valid+data register; data only moves with a valid word so idle stages stay quiet
module fp_delay_stage #(
  parameter int W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic load,
  input  logic src_valid,
  input  logic [W-1:0] src_data,
  output logic valid,
  output logic [W-1:0] data
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data <= '0;
    end else begin
      valid <= flush ? 1'b0 : load ? src_valid : valid;
      if (load && src_valid && !flush) data <= src_data;
    end
  end
endmodule

// File: rtl/fp_elastic_delay.sv
// fp_elastic_delay: DEPTH-stage elastic delay line for floating-point words with bubble collapsing
module fp_elastic_delay
  import fp_delay_pkg::*;
#(
  parameter int MANTISSA_LENGTH = MANTISSA_LENGTH_DEF,
  parameter int EXP_LENGTH = EXP_LENGTH_DEF,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  input logic flush,
  fp_elastic_delay_if.slave bus
);
  localparam int W = fp_width(MANTISSA_LENGTH, EXP_LENGTH);
  localparam int CW = $clog2(DEPTH + 1);
  if (DEPTH < 1) begin : g_bad_depth
    $error("fp_elastic_delay: DEPTH must be >= 1");
  end
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] acc;
  logic [W-1:0] d [DEPTH];
  logic [CW-1:0] occ;
  logic in_fire, out_fire;
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    logic sv;
    logic [W-1:0] sd;
    if (i == 0) begin : g_head
      assign sv = bus.in_valid;
      assign sd = bus.in_data;
    end else begin : g_tail
      assign sv = v[i-1];
      assign sd = d[i-1];
    end
    // A stage may take a word if any stage at or after it has a hole, or the output drains
    assign acc[i] = ~&v[DEPTH-1:i] | bus.out_ready;
    fp_delay_stage #(.W(W)) u_stage (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .load(acc[i]),
      .src_valid(sv),
      .src_data(sd),
      .valid(v[i]),
      .data(d[i])
    );
  end
  assign in_fire = bus.in_valid & acc[0];
  assign out_fire = v[DEPTH-1] & bus.out_ready;
  always_ff @(posedge clk) begin
    if (reset || flush) occ <= '0;
    else occ <= occ + CW'(in_fire) - CW'(out_fire);
  end
  assign bus.in_ready = acc[0];
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data = d[DEPTH-1];
  assign bus.occupancy = occ;
endmodule
